// File: rtl/bf_seg_scan.sv
// bf_seg_scan: multiplexed seven-segment hex display scanner.
// Ports: system1000 clock, system1000_rstn async active-low reset,
//   value/dp/load capture the shadow digits, blank forces the display dark,
//   an one-hot anode select, seg {dp,g,f,e,d,c,b,a}, frame_tick start-of-frame.
// Optional macro SEG_LZ_BLANK_EN: blank leading-zero digits (digit 0 and
//   digits with dp set are always shown).
module bf_seg_scan #(
    parameter int NDIGITS    = 8,
    parameter int DIV        = 100000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                   system1000,
    input  logic                   system1000_rstn,
    input  logic [4*NDIGITS-1:0]   value,
    input  logic [NDIGITS-1:0]     dp,
    input  logic                   load,
    input  logic                   blank,
    output logic [NDIGITS-1:0]     an,
    output logic [7:0]             seg,
    output logic                   frame_tick
);

    localparam int   PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int   IW  = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic POL = (ACTIVE_LOW != 0);

    logic [PW-1:0]          r_presc;
    logic [IW-1:0]          r_idx;
    logic [4*NDIGITS-1:0]   r_val;
    logic [NDIGITS-1:0]     r_dp;
    logic [NDIGITS-1:0]     r_an;
    logic [7:0]             r_seg;
    logic                   r_tick;

    logic                   w_wrap;
    logic [3:0]             w_nib;
    logic                   w_dpb;
    logic [NDIGITS-1:0]     w_onehot;
    logic [6:0]             w_glyph;
    logic [7:0]             w_seg_on;
    logic [NDIGITS-1:0]     w_an_nxt;
    logic [7:0]             w_seg_nxt;
    logic                   w_tick_nxt;
`ifdef SEG_LZ_BLANK_EN
    logic                   w_hi_nz;
    logic                   w_lz;
`endif

    assign w_wrap = (r_presc == PW'(DIV - 1));

    // Select the nibble, dp bit and anode for the current index.
    always_comb begin
        w_nib    = 4'h0;
        w_dpb    = 1'b0;
        w_onehot = '0;
        for (int k = 0; k < NDIGITS; k++) begin
            if (r_idx == IW'(k)) begin
                w_nib       = r_val[4*k +: 4];
                w_dpb       = r_dp[k];
                w_onehot[k] = 1'b1;
            end
        end
    end

    always_comb begin
        case (w_nib)
            4'h0:    w_glyph = 7'h3F;
            4'h1:    w_glyph = 7'h06;
            4'h2:    w_glyph = 7'h5B;
            4'h3:    w_glyph = 7'h4F;
            4'h4:    w_glyph = 7'h66;
            4'h5:    w_glyph = 7'h6D;
            4'h6:    w_glyph = 7'h7D;
            4'h7:    w_glyph = 7'h07;
            4'h8:    w_glyph = 7'h7F;
            4'h9:    w_glyph = 7'h6F;
            4'hA:    w_glyph = 7'h77;
            4'hB:    w_glyph = 7'h7C;
            4'hC:    w_glyph = 7'h39;
            4'hD:    w_glyph = 7'h5E;
            4'hE:    w_glyph = 7'h79;
            default: w_glyph = 7'h71;
        endcase
    end

`ifdef SEG_LZ_BLANK_EN
    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        w_hi_nz = 1'b0;
        for (int k = 0; k < NDIGITS; k++) begin
            if ((IW'(k) >= r_idx) && (r_val[4*k +: 4] != 4'h0)) begin
                w_hi_nz = 1'b1;
            end
        end
    end

    assign w_lz     = !w_hi_nz && (r_idx != '0) && !w_dpb;
    assign w_seg_on = w_lz ? 8'h00 : {w_dpb, w_glyph};
`else
    assign w_seg_on = {w_dpb, w_glyph};
`endif

    assign w_an_nxt   = blank ? '0 : w_onehot;
    assign w_seg_nxt  = blank ? 8'h00 : w_seg_on;
    assign w_tick_nxt = (r_idx == '0) && (r_presc == '0);

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_val   <= '0;
            r_dp    <= '0;
            r_an    <= {NDIGITS{POL}};
            r_seg   <= {8{POL}};
            r_tick  <= 1'b0;
        end else begin
            if (w_wrap) begin
                r_presc <= '0;
                if (r_idx == IW'(NDIGITS - 1)) begin
                    r_idx <= '0;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end else begin
                r_presc <= r_presc + 1'b1;
            end
            if (load) begin
                r_val <= value;
                r_dp  <= dp;
            end
            // Outputs use pre-edge index/shadow, so a same-edge load
            // shows up only on the next update.
            r_an   <= {NDIGITS{POL}} ^ w_an_nxt;
            r_seg  <= {8{POL}} ^ w_seg_nxt;
            r_tick <= w_tick_nxt;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign frame_tick = r_tick;

endmodule

// File: doc/bf_seg_scan.md
BF_SEG_SCAN -- requirements
Module: bf_seg_scan

Interface
REQ-001 Parameter NDIGITS, default 8: number of multiplexed digits, legal range 1..16.
REQ-002 Parameter DIV, default 100000: clock cycles each digit is held, legal range >=1.
REQ-003 Parameter ACTIVE_LOW, default 1: when 1, an and seg are active-low; when 0, they are active-high.
REQ-004 Port system1000, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port system1000_rstn, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port value, input, 4*NDIGITS bits: hex nibbles; nibble k drives digit k, and digit 0 is the rightmost.
REQ-007 Port dp, input, NDIGITS bits: decimal-point enables; bit k drives digit k.
REQ-008 Port load, input, 1 bit: capture strobe for value and dp.
REQ-009 Port blank, input, 1 bit: global display blank.
REQ-010 Port an, output, NDIGITS bits: one-hot digit anode select.
REQ-011 Port seg, output, 8 bits, ordered {dp,g,f,e,d,c,b,a}: segment drive.
REQ-012 Port frame_tick, output, 1 bit: one-cycle pulse at the start of each scan frame.

Function
REQ-013 The block SHALL capture value and dp into shadow registers on every edge where load=1; no other handshake exists, and a load is never refused.
REQ-014 The display SHALL use only the shadow registers; changes on value and dp while load=0 SHALL have no visible effect.
REQ-015 A prescaler SHALL count 0..DIV-1 and wrap to 0; when DIV=1 it SHALL remain 0 and every cycle counts as a wrap.
REQ-016 The digit index SHALL advance on each prescaler wrap and go from NDIGITS-1 back to 0; when NDIGITS=1 it SHALL remain 0.
REQ-017 an, seg and frame_tick SHALL be registered and SHALL reflect the index and shadow state as they were before the same edge, so each digit is shown for exactly DIV consecutive cycles.
REQ-018 an SHALL assert only the bit matching the index; all other bits SHALL be inactive.
REQ-019 Digits 0-9 and A-F SHALL decode to standard seven-segment hex glyphs; examples (active-high, before polarity inversion): 0=0x3F, 1=0x06, 8=0x7F, A=0x77, F=0x71.
REQ-020 seg[7] SHALL equal the shadow dp bit of the current digit.
REQ-021 frame_tick SHALL be 1 for exactly the first cycle in which an selects digit 0.
REQ-022 When blank=1, an and seg SHALL be all-inactive from the next edge onward.
REQ-023 While blank=1, the prescaler, the index and frame_tick SHALL continue unaffected.
REQ-024 A load on the same edge as an index advance SHALL take effect at the following output update; no mixed or torn glyph is permitted.

Reset
REQ-025 While system1000_rstn=0, the prescaler, the index, shadow value and shadow dp SHALL all be 0.
REQ-026 While system1000_rstn=0, an and seg SHALL be all-inactive and frame_tick SHALL be 0.
REQ-027 Reset asserted mid-frame SHALL clear all state immediately, without waiting for a clock edge.
REQ-028 On the first edge after reset release, the block SHALL select digit 0, showing glyph "0", and SHALL pulse frame_tick.

Configuration
REQ-029 With macro SEG_LZ_BLANK_EN defined, any digit above the most-significant nonzero shadow nibble SHALL drive seg all-inactive.
REQ-030 With SEG_LZ_BLANK_EN defined, the exemptions are: digit 0 is never blanked, and a digit whose dp bit is 1 is never blanked; an keeps scanning normally in all cases.
REQ-031 With SEG_LZ_BLANK_EN undefined, every digit SHALL display its glyph, and the block SHALL contain no blanking logic.

Verification
All scenarios use NDIGITS=8, DIV=4, ACTIVE_LOW=1.
REQ-032 Reset release, no load -> an cycles 0xFE for 4 cycles, then 0xFD for 4 cycles, and so on to 0x7F; seg=0xC0; frame_tick pulses every 32 cycles.
REQ-033 Load value=0x000012AF, dp=0x00 -> seg sequence per digit is 0x8E, 0x88, 0xA4, 0xF9, then 0xC0 ×4 without the macro, or 0xFF ×4 with SEG_LZ_BLANK_EN.
REQ-034 Load value=0x88888888, dp=0x01 -> digit 0 seg=0x00 and digits 1-7 seg=0x80.
REQ-035 blank=1 for 10 cycles mid-frame -> an=0xFF and seg=0xFF throughout, and the frame_tick period stays 32 cycles.
REQ-036 Reset asserted asynchronously mid-digit 5 -> an=0xFF and seg=0xFF before the next edge; after release, the scan restarts at digit 0 with seg=0xC0.
